axi_lite_slave_regs: RTL

//  AXI4-Lite slave register bank that terminates the AW/W/B/AR/R channels driven by axi_lite_master.

---
 rtl/axi_lite_slave_regs_pkg.sv | 24 ++
 rtl/axi_lite_slave_regs_if.sv | 43 ++++
 rtl/axi_lite_slave_regs_bank.sv | 53 +++++
 rtl/axi_lite_slave_regs.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/axi_lite_slave_regs_pkg.sv
// Shared definitions for the AXI4-Lite slave register bank: default widths,
// response codes and the write/read channel state encodings.
package axi_lite_slave_regs_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_REGS = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_GOT_AW,
    WR_GOT_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

endpackage

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) shared by the master and this slave.
interface axi_lite_slave_regs_if
  import axi_lite_slave_regs_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_slave_regs_bank.sv
// Byte-strobed register array with a combinational read mux; the top slot
// of the index space returns the live hardware status word.
module axi_lite_slave_regs_bank
  import axi_lite_slave_regs_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                IDX_W     = DEF_ADDR_W - 2,
  parameter int                NUM_REGS  = DEF_NUM_REGS,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          we,
  input  logic [IDX_W-1:0]              widx,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [DATA_W/8-1:0]           wstrb,
  input  logic [IDX_W-1:0]              ridx,
  input  logic [DATA_W-1:0]             hw_status,
  output logic [DATA_W-1:0]             rd_val,
  output logic [(NUM_REGS-1)*DATA_W-1:0] regs_out
);

  logic [DATA_W-1:0] regs [0:NUM_REGS-2];

  // Writable registers: reset to RESET_VAL, update only the strobed byte lanes.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS-1; i++) regs[i] <= RESET_VAL;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS-1; i++) begin
        if (int'(widx) == i) begin
          for (int b = 0; b < DATA_W/8; b++) begin
            if (wstrb[b]) regs[i][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read mux: status slot first, then the writable registers, zero otherwise.
  always_comb begin
    rd_val = '0;
    if (int'(ridx) == NUM_REGS-1) rd_val = hw_status;
    for (int i = 0; i < NUM_REGS-1; i++) begin
      if (int'(ridx) == i) rd_val = regs[i];
    end
  end

  for (genvar gi = 0; gi < NUM_REGS-1; gi++) begin : g_out
    assign regs_out[gi*DATA_W +: DATA_W] = regs[gi];
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank: independent write (AW/W/B) and read (AR/R)
// channel FSMs in front of a byte-strobed register array with a status slot.
module axi_lite_slave_regs
  import axi_lite_slave_regs_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                NUM_REGS  = DEF_NUM_REGS,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  axi_lite_slave_regs_if.slave           s,
  input  logic [DATA_W-1:0]              hw_status,
  output logic [(NUM_REGS-1)*DATA_W-1:0] regs_out
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;

  // Misaligned, out-of-range, and (for writes) status-register accesses are errors.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic is_write);
    int idx;
    idx = int'(a[ADDR_W-1:2]);
    return (a[1:0] != 2'b00) || (idx >= NUM_REGS) || (is_write && (idx == NUM_REGS-1));
  endfunction

  wr_state_t         wr_state, wr_next;
  rd_state_t         rd_state, rd_next;
  logic              aw_hs, w_hs, ar_hs, commit;
  logic              wr_err, rd_err;
  logic [ADDR_W-1:0] aw_addr_q, wr_addr;
  logic [DATA_W-1:0] w_data_q, wr_data, rd_val;
  logic [STRB_W-1:0] w_strb_q, wr_strb;

  assign aw_hs    = s.awvalid & s.awready;
  assign w_hs     = s.wvalid & s.wready;
  assign ar_hs    = s.arvalid & s.arready;
  assign s.bvalid = (wr_state == WR_RESP);
  assign s.rvalid = (rd_state == RD_RESP);

  // Commit takes whichever of address/data is already held, else the live bus value.
  assign wr_addr = (wr_state == WR_GOT_AW) ? aw_addr_q : s.awaddr;
  assign wr_data = (wr_state == WR_GOT_W)  ? w_data_q  : s.wdata;
  assign wr_strb = (wr_state == WR_GOT_W)  ? w_strb_q  : s.wstrb;
  assign wr_err  = addr_err(wr_addr, 1'b1);
  assign rd_err  = addr_err(s.araddr, 1'b0);

  // Write FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  // Write FSM next state, channel readies and commit strobe.
  always_comb begin
    wr_next   = wr_state;
    s.awready = 1'b0;
    s.wready  = 1'b0;
    commit    = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        s.awready = 1'b1;
        s.wready  = 1'b1;
        if (s.awvalid && s.wvalid) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end else if (s.awvalid) begin
          wr_next = WR_GOT_AW;
        end else if (s.wvalid) begin
          wr_next = WR_GOT_W;
        end
      end
      WR_GOT_AW: begin
        s.wready = 1'b1;
        if (s.wvalid) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_GOT_W: begin
        s.awready = 1'b1;
        if (s.awvalid) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s.bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // Hold registers for whichever write channel arrives first; only read when flagged.
  always_ff @(posedge aclk) begin
    if (aw_hs) aw_addr_q <= s.awaddr;
    if (w_hs) begin
      w_data_q <= s.wdata;
      w_strb_q <= s.wstrb;
    end
  end

  // Write response code, loaded on the commit edge and held until B completes.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)      s.bresp <= RESP_OKAY;
    else if (commit) s.bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
  end

  // Read FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  // Read FSM next state and address ready.
  always_comb begin
    rd_next   = rd_state;
    s.arready = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        s.arready = 1'b1;
        if (s.arvalid) rd_next = RD_RESP;
      end
      RD_RESP: begin
        if (s.rready) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Read data/response captured at the AR edge, so a same-edge write is not seen.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s.rdata <= '0;
      s.rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s.rdata <= rd_err ? '0 : rd_val;
      s.rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  axi_lite_slave_regs_bank #(
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W),
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .aclk      (aclk),
    .areset    (areset),
    .we        (commit & ~wr_err),
    .widx      (wr_addr[ADDR_W-1:2]),
    .wdata     (wr_data),
    .wstrb     (wr_strb),
    .ridx      (s.araddr[ADDR_W-1:2]),
    .hw_status (hw_status),
    .rd_val    (rd_val),
    .regs_out  (regs_out)
  );

endmodule
